sort_buffer_responder: RTL

- Device-side responder for the sorter test harness protocol: the harness pushes a frame of up to R_SZ words, then pops them back in sorted order.
- Implemented as a register-array insertion sorter: one word inserted per cycle, one word popped per cycle, valid/ready handshake on both sides.
- Sits under the VGA test harness as an alternative DUT alongside the stack and tree sorters. Its running checksum and occupancy feed the harness error flags.

---
 rtl/sort_buffer_responder_if.sv | 22 ++
 rtl/sort_buffer_responder.sv | 118 +++++++++++
 2 files changed

// File: rtl/sort_buffer_responder_if.sv
// Push/pop handshake bundle between the sorter test harness (master) and a
// sorting responder (slave).
interface sort_buffer_responder_if #(
    parameter int HBIT = 15
);
    logic          push_valid;
    logic          push_ready;
    logic [HBIT:0] push_data;
    logic          pop_valid;
    logic          pop_ready;
    logic [HBIT:0] pop_data;

    modport master (
        output push_valid, push_data, pop_ready,
        input  push_ready, pop_valid, pop_data
    );

    modport slave (
        input  push_valid, push_data, pop_ready,
        output push_ready, pop_valid, pop_data
    );
endinterface

// File: rtl/sort_buffer_responder.sv
// Register-array insertion sorter: fills one word per cycle in sorted position,
// then drains from the head one word per cycle, with a running push-minus-pop checksum.
module sort_buffer_responder #(
    parameter int HBIT    = 15,
    parameter int R_SZ    = 64,
    parameter int DESCEND = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   drain,
    sort_buffer_responder_if.slave bus,
    output logic [11:0]            count,
    output logic [31:0]            sum,
    output logic                   draining
);
    localparam int DATA_W = HBIT + 1;
    localparam int CNT_W  = 12;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(R_SZ);

    typedef enum logic {S_FILL, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] e_q [R_SZ];
    logic [DATA_W-1:0] e_d [R_SZ];
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       sum_q, sum_d;
    logic [R_SZ-1:0]   take;
    logic [R_SZ-1:0]   take_prev;
    logic              push_fire;
    logic              pop_fire;

    function automatic logic before_f(input logic [DATA_W-1:0] a,
                                      input logic [DATA_W-1:0] b);
        if (DESCEND != 0) return a > b;
        return a < b;
    endfunction

    function automatic logic [31:0] widen_f(input logic [DATA_W-1:0] v);
        return 32'(v);
    endfunction

    assign bus.push_ready = (state_q == S_FILL) && (count_q < FULL);
    assign bus.pop_valid  = (state_q == S_DRAIN) && (count_q != '0);
    assign bus.pop_data   = e_q[0];
    assign count          = count_q;
    assign sum            = sum_q;
    assign draining       = (state_q == S_DRAIN);

    assign push_fire = bus.push_valid & bus.push_ready;
    assign pop_fire  = bus.pop_valid & bus.pop_ready;

    // take[i]: new word lands at or before slot i; strict compare keeps equals stable
    always_comb begin
        take = '0;
        for (int i = 0; i < R_SZ; i++) begin
            take[i] = (CNT_W'(i) >= count_q) | before_f(bus.push_data, e_q[i]);
        end
    end

    assign take_prev = {take[R_SZ-2:0], 1'b0};

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sum_d   = sum_q;
        for (int i = 0; i < R_SZ; i++) begin
            e_d[i] = e_q[i];
        end

        if (clr) begin
            state_d = S_FILL;
            count_d = '0;
            sum_d   = '0;
        end else if (state_q == S_FILL) begin
            if (push_fire) begin
                count_d = count_q + CNT_W'(1);
                sum_d   = sum_q + widen_f(bus.push_data);
                if (take[0]) e_d[0] = bus.push_data;
                for (int i = 1; i < R_SZ; i++) begin
                    if (take_prev[i])  e_d[i] = e_q[i-1];
                    else if (take[i])  e_d[i] = bus.push_data;
                end
            end
            // An empty buffer ignores drain; a push in the same cycle still counts
            if ((count_d == FULL) || (drain && (count_d != '0))) begin
                state_d = S_DRAIN;
            end
        end else begin
            if (pop_fire) begin
                count_d = count_q - CNT_W'(1);
                sum_d   = sum_q - widen_f(e_q[0]);
                for (int i = 0; i < R_SZ - 1; i++) begin
                    e_d[i] = e_q[i+1];
                end
                if (count_d == '0) state_d = S_FILL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FILL;
            count_q <= '0;
            sum_q   <= '0;
            for (int i = 0; i < R_SZ; i++) begin
                e_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            for (int i = 0; i < R_SZ; i++) begin
                e_q[i] <= e_d[i];
            end
        end
    end
endmodule
